// File: rtl/uart_32bit_tx_if.sv
// Handshake and line signals between the core-side controller and the
// 32-bit UART transmitter.
interface uart_32bit_tx_if;
    logic [31:0] data_in;
    logic        data_start;
    logic        tx;
    logic        busy;
    logic        data_end;

    modport master (
        output data_in,
        output data_start,
        input  tx,
        input  busy,
        input  data_end
    );

    modport slave (
        input  data_in,
        input  data_start,
        output tx,
        output busy,
        output data_end
    );
endinterface

// File: rtl/uart_32bit_tx.sv
// Sends one 32-bit word as four back-to-back 8N1 frames, least-significant
// byte first, with its own baud counter and shift register.
module uart_32bit_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic            clk,
    input  logic            reset,
    uart_32bit_tx_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t              state_r;
    logic [31:0]         word_r;
    logic [7:0]          shift_r;
    logic [BAUD_W-1:0]   baud_r;
    logic [2:0]          bit_idx_r;
    logic [1:0]          byte_idx_r;
    logic                tx_r;
    logic                busy_r;
    logic                data_end_r;
    logic [7:0]          byte_sel_s;

    // Byte of the latched word that the next frame carries.
    always_comb begin
        byte_sel_s = word_r[{byte_idx_r, 3'b000} +: 8];
    end

    // Frame sequencer; tx/busy/data_end are set one cycle ahead of the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            word_r     <= 32'd0;
            shift_r    <= 8'd0;
            baud_r     <= '0;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 2'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            data_end_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_r     <= '0;
                    data_end_r <= 1'b0;
                    if (bus.data_start) begin
                        word_r     <= bus.data_in;
                        byte_idx_r <= 2'd0;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= START_BIT;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START_BIT: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r    <= '0;
                        bit_idx_r <= 3'd0;
                        shift_r   <= byte_sel_s;
                        tx_r      <= byte_sel_s[0];
                        state_r   <= DATA_BITS;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                DATA_BITS: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP_BIT;
                        end else begin
                            // tx is registered, so it takes the bit that becomes shift[0].
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                STOP_BIT: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r <= '0;
                        if (byte_idx_r == 2'd3) begin
                            tx_r       <= 1'b1;
                            data_end_r <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                            tx_r       <= 1'b0;
                            state_r    <= START_BIT;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                DONE: begin
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                    data_end_r <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    baud_r     <= '0;
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                    data_end_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx       = tx_r;
    assign bus.busy     = busy_r;
    assign bus.data_end = data_end_r;
endmodule

// File: tb/tb_uart_32bit_tx.sv
// Directed-plus-random bench for uart_32bit_tx at 16 clocks per bit, checked
// cycle by cycle against an ideal 8N1 line model.
module tb_uart_32bit_tx;
    localparam int CPB       = 16;
    localparam int WORD_CYC  = 40 * CPB;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic line_r [0:WORD_CYC-1];

    uart_32bit_tx_if bus ();

    uart_32bit_tx #(
        .CLK_FREQ (1600),
        .BAUD_RATE(100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal line level for bit slot idx (0..39): per byte start 0, 8 data LSB first, stop 1.
    function automatic logic exp_bit(input logic [31:0] w, input int idx);
        int b;
        int p;
        b = idx / 10;
        p = idx % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[8 * b + p - 1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, {31'd0, bus.tx}, 32'd1);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_end"}, {31'd0, bus.data_end}, 32'd0);
    endtask

    // Caller has just set data_start=1 at a negedge; acceptance is the next posedge (k).
    // Cycle k+c is sampled at its negedge; returns during the first IDLE cycle (c=642).
    task automatic check_word(input logic [31:0] w, input bit release_start,
                              input int change_at, input logic [31:0] alt, input int max_c);
        logic        e_tx;
        logic        e_busy;
        logic        e_de;
        logic [31:0] got;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            if (c == 1 && release_start) bus.data_start = 1'b0;
            if (c == change_at) bus.data_in = alt;
            if (c <= WORD_CYC) begin
                e_tx = exp_bit(w, (c - 1) / CPB);
                e_busy = 1'b1;
                e_de = 1'b0;
                line_r[c - 1] = bus.tx;
            end else if (c == WORD_CYC + 1) begin
                e_tx = 1'b1;
                e_busy = 1'b1;
                e_de = 1'b1;
            end else begin
                e_tx = 1'b1;
                e_busy = 1'b0;
                e_de = 1'b0;
            end
            check("tx", {31'd0, bus.tx}, {31'd0, e_tx});
            check("busy", {31'd0, bus.busy}, {31'd0, e_busy});
            check("data_end", {31'd0, bus.data_end}, {31'd0, e_de});
        end
        if (max_c >= WORD_CYC) begin
            got = 32'd0;
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < 8; i++) begin
                    got[8 * b + i] = line_r[b * 10 * CPB + CPB * (i + 1) + CPB / 2];
                end
            end
            check("decoded_word", got, w);
        end
    endtask

    initial begin
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] loop_words [3];
        int          run;
        int          runs;

        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.data_in = 32'h1234_5678;
        bus.data_start = 1'b1;

        // Reset held with a pending request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset");
        end
        reset = 1'b1;
        bus.data_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_idle("post_reset");
        end

        // Single directed word.
        bus.data_in = 32'hA5C3_0F81;
        bus.data_start = 1'b1;
        check_word(32'hA5C3_0F81, 1'b1, 0, 32'd0, 642);

        // Back-to-back words, each restarted in the first IDLE cycle.
        loop_words[0] = 32'hDEAD_BEEF;
        loop_words[1] = 32'h0000_0000;
        loop_words[2] = 32'hFFFF_FFFF;
        for (int n = 0; n < 3; n++) begin
            bus.data_in = loop_words[n];
            bus.data_start = 1'b1;
            check_word(loop_words[n], 1'b1, 0, 32'd0, 642);
        end

        // Held request with data_in changed mid-word.
        w1 = $urandom;
        w2 = $urandom;
        bus.data_in = w1;
        bus.data_start = 1'b1;
        check_word(w1, 1'b0, 100, w2, 642);
        check_word(w2, 1'b1, 0, 32'd0, 642);

        // Reset during byte 2, data bit 3.
        w1 = $urandom;
        bus.data_in = w1;
        bus.data_start = 1'b1;
        check_word(w1, 1'b1, 0, 32'd0, 2 * 10 * CPB + 1 + 4 * CPB + 5);
        reset = 1'b0;
        @(negedge clk);
        check_idle("midreset");
        reset = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            check_idle("after_midreset");
        end
        w2 = $urandom;
        bus.data_in = w2;
        bus.data_start = 1'b1;
        check_word(w2, 1'b1, 0, 32'd0, 642);

        // Alternating pattern: every run on the line must be one bit time.
        bus.data_in = 32'h5555_5555;
        bus.data_start = 1'b1;
        check_word(32'h5555_5555, 1'b1, 0, 32'd0, 642);
        run = 1;
        runs = 0;
        for (int i = 1; i < WORD_CYC; i++) begin
            if (line_r[i] == line_r[i - 1]) begin
                run++;
            end else begin
                check("bit_width", run, CPB);
                runs++;
                run = 1;
            end
        end
        check("bit_width_last", run, CPB);
        check("bit_count", runs + 1, 40);

        // Random words with random idle gaps.
        for (int n = 0; n < 4; n++) begin
            run = $urandom_range(0, 20);
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                check_idle("gap");
            end
            w1 = $urandom;
            bus.data_in = w1;
            bus.data_start = 1'b1;
            check_word(w1, 1'b1, 0, 32'd0, 642);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_32bit_tx.md
Name: uart_32bit_tx

Overview:
- Serializes one 32-bit word onto a UART line as four back-to-back 8N1 frames, least-significant byte first.
- Counterpart of the 32-bit UART receive path. A word sent by this block and received by the receiver reassembles to the identical value.
- Contains its own bit-timing counter and shift logic; no byte-level submodule.
- Sits on the debug/program-load link of the RISC-V SoC, driven by the core-side controller.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE: derived local, integer-truncated. Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- data_in  input  32  word to transmit. Sampled only when a start is accepted.
- data_start  input  1  transmit request. Level-sampled each cycle.
- tx  output  1  serial line. Idle high.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- data_end  output  1  one-cycle pulse when the 4th stop bit completes.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, tx=1, busy=0, data_end=0, word/shift registers=0, bit/byte/baud counters=0. Takes effect from any state.
  - Mid-frame reset: tx high from the next cycle, no data_end, word discarded.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: tx=1, busy=0. If data_start=1, latch data_in into the word register, byte_idx=0, and go to START_BIT. data_start while not in IDLE is ignored (no queuing).
  - START_BIT: tx=0 for CLKS_PER_BIT cycles, then go to DATA_BITS with bit_idx=0. The shift register is loaded with word[8*byte_idx+:8].
  - DATA_BITS: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each. After bit_idx=7 go to STOP_BIT.
  - STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<3: byte_idx+1, go to START_BIT. No idle gap between frames.
    - if byte_idx==3: go to DONE.
  - DONE: one cycle. tx=1, busy=1, data_end=1, then IDLE. data_start in DONE is ignored.
- Timing, with acceptance at edge k:
  - tx first low during cycle k+1.
  - Whole word occupies exactly 40*CLKS_PER_BIT cycles.
  - data_end high during cycle k+1+40*CLKS_PER_BIT.
  - busy low again the following cycle.
  - Earliest next acceptance is at the edge that ends the first IDLE cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
- Byte order: data_in[7:0], [15:8], [23:16], [31:24]. Bit order within a byte is LSB first.
- data_in changes after acceptance do not affect the frame in flight.

Test Plan:
- All tests use CLK_FREQ=1600, BAUD_RATE=100 (CLKS_PER_BIT=16).
- Reset: hold reset=0 for 3 cycles with data_start=1 -> tx=1, busy=0, data_end=0 throughout. No transmission after release until data_start is seen in IDLE.
- Single word: data_in=32'hA5C3_0F81, pulse data_start 1 cycle. Line sampler at mid-bit -> bytes 81,0F,C3,A5, each with start=0 and stop=1. tx first low at k+1. data_end a single pulse at k+641. busy high for cycles k+1..k+641.
- Loopback: tx wired to the 32-bit receiver, send 32'hDEAD_BEEF, then 32'h0000_0000, then 32'hFFFF_FFFF back-to-back (restart on the IDLE cycle after each data_end) -> receiver data_out matches each word and its data_end fires once per word.
- Busy ignore: hold data_start=1 continuously and change data_in at cycle k+100 -> first word transmitted unchanged. A second word (the data_in value present in the next IDLE cycle) starts exactly 2 cycles after data_end.
- Mid-frame reset: assert reset=0 during byte 2, data bit 3 -> tx=1 the next cycle, busy=0, no data_end. A fresh start afterwards transmits a full correct word.
- Frame timing: measure every bit width on tx for word 32'h5555_5555 -> each bit exactly 16 cycles. No idle between stop bit and the next start bit.
